// File: rtl/alu_sequencer_pkg.sv
// Shared types and encodings for the ArgonALU command-bus sequencer:
// bus command codes, ALU opcodes, FSM states and the unary-op helper.
package alu_sequencer_pkg;

  localparam int WORDSIZE  = 16;
  localparam int OP_WIDTH  = 4;
  localparam int COM_WIDTH = 3;

  typedef logic [COM_WIDTH-1:0] com_t;

  localparam com_t com_nop     = 3'd0;
  localparam com_t com_latchA  = 3'd1;
  localparam com_t com_latchB  = 3'd2;
  localparam com_t com_latchF  = 3'd3;
  localparam com_t com_latchOp = 3'd4;
  localparam com_t com_outputY = 3'd5;
  localparam com_t com_outputF = 3'd6;

  localparam logic [OP_WIDTH-1:0] ALU_ADD = 4'h0;
  localparam logic [OP_WIDTH-1:0] ALU_ADC = 4'h1;
  localparam logic [OP_WIDTH-1:0] ALU_SUB = 4'h2;
  localparam logic [OP_WIDTH-1:0] ALU_SBC = 4'h3;
  localparam logic [OP_WIDTH-1:0] ALU_INC = 4'h4;
  localparam logic [OP_WIDTH-1:0] ALU_DEC = 4'h5;
  localparam logic [OP_WIDTH-1:0] ALU_AND = 4'h6;
  localparam logic [OP_WIDTH-1:0] ALU_OR  = 4'h7;
  localparam logic [OP_WIDTH-1:0] ALU_XOR = 4'h8;

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, WR_F, WR_OP, RD_Y, RD_F, RESP
  } seq_state_t;

  // INC/DEC only consume operand A, so operand B is never sent for them.
  function automatic logic is_unary(input logic [OP_WIDTH-1:0] op);
    return (op == ALU_INC) || (op == ALU_DEC);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake plus ALU command bus. Both handshakes use
// valid/ready: a transfer happens on a clock edge where valid and ready are both 1.
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic                 i_ReqValid;
  logic                 o_ReqReady;
  logic [OP_WIDTH-1:0]  i_ReqOp;
  logic [WORDSIZE-1:0]  i_ReqA;
  logic [WORDSIZE-1:0]  i_ReqB;
  logic                 i_ReqChain;

  logic                 o_RspValid;
  logic                 i_RspReady;
  logic [WORDSIZE-1:0]  o_RspResult;
  logic [WORDSIZE-1:0]  o_RspFlags;
  logic                 o_RspError;

  logic [COM_WIDTH-1:0] o_Command;
  logic [WORDSIZE-1:0]  o_BusData;
  logic                 o_BusValid;
  logic [WORDSIZE-1:0]  i_BusData;
  logic                 i_BusValid;

  modport master (
    input  i_ReqValid, i_ReqOp, i_ReqA, i_ReqB, i_ReqChain, i_RspReady,
    input  i_BusData, i_BusValid,
    output o_ReqReady, o_RspValid, o_RspResult, o_RspFlags, o_RspError,
    output o_Command, o_BusData, o_BusValid
  );

  modport slave (
    output i_ReqValid, i_ReqOp, i_ReqA, i_ReqB, i_ReqChain, i_RspReady,
    output i_BusData, i_BusValid,
    input  o_ReqReady, o_RspValid, o_RspResult, o_RspFlags, o_RspError,
    input  o_Command, o_BusData, o_BusValid
  );

endinterface

// File: rtl/alu_sequencer.sv
// Turns one {op, A, B, chain} request into the ArgonALU command sequence
// (latch A/B/F/op, read Y, read F) and returns {result, flags} with a timeout abort.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  alu_sequencer_if.master bus,
  output seq_state_t      o_DbgState
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t          state_q, state_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [WORDSIZE-1:0] a_q, a_d;
  logic [WORDSIZE-1:0] b_q, b_d;
  logic                chain_q, chain_d;
  logic [WORDSIZE-1:0] result_q, result_d;
  logic [WORDSIZE-1:0] flags_q, flags_d;
  logic                error_q, error_d;
  logic [WORDSIZE-1:0] saved_q, saved_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [COM_WIDTH-1:0] command;
  logic [WORDSIZE-1:0]  bus_data;
  logic                 bus_valid;
  logic                 timed_out;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      chain_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      error_q  <= 1'b0;
      saved_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      chain_q  <= chain_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      error_q  <= error_d;
      saved_q  <= saved_d;
      cnt_q    <= cnt_d;
    end
  end

  // The last stalled cycle of a read state is the one that aborts.
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    chain_d  = chain_q;
    result_d = result_q;
    flags_d  = flags_q;
    error_d  = error_q;
    saved_d  = saved_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_ReqValid) begin
          op_d     = bus.i_ReqOp;
          a_d      = bus.i_ReqA;
          b_d      = bus.i_ReqB;
          chain_d  = bus.i_ReqChain;
          result_d = '0;
          flags_d  = '0;
          error_d  = 1'b0;
          state_d  = WR_A;
        end
      end
      WR_A:  state_d = is_unary(op_q) ? WR_F : WR_B;
      WR_B:  state_d = WR_F;
      WR_F:  state_d = WR_OP;
      WR_OP: begin
        cnt_d   = '0;
        state_d = RD_Y;
      end
      RD_Y: begin
        if (bus.i_BusValid) begin
          result_d = bus.i_BusData;
          cnt_d    = '0;
          state_d  = RD_F;
        end else if (timed_out) begin
          result_d = '0;
          flags_d  = '0;
          error_d  = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_F: begin
        if (bus.i_BusValid) begin
          flags_d = bus.i_BusData;
          saved_d = bus.i_BusData;
          state_d = RESP;
        end else if (timed_out) begin
          result_d = '0;
          flags_d  = '0;
          error_d  = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.i_RspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    command   = com_nop;
    bus_data  = '0;
    bus_valid = 1'b0;
    unique case (state_q)
      WR_A: begin
        command   = com_latchA;
        bus_data  = a_q;
        bus_valid = 1'b1;
      end
      WR_B: begin
        command   = com_latchB;
        bus_data  = b_q;
        bus_valid = 1'b1;
      end
      WR_F: begin
        command   = com_latchF;
        bus_data  = chain_q ? saved_q : '0;
        bus_valid = 1'b1;
      end
      WR_OP: begin
        command   = com_latchOp;
        bus_data  = {{(WORDSIZE-OP_WIDTH){1'b0}}, op_q};
        bus_valid = 1'b1;
      end
      RD_Y:    command = com_outputY;
      RD_F:    command = com_outputF;
      default: command = com_nop;
    endcase
  end

  assign bus.o_ReqReady  = (state_q == IDLE);
  assign bus.o_RspValid  = (state_q == RESP);
  assign bus.o_RspResult = result_q;
  assign bus.o_RspFlags  = flags_q;
  assign bus.o_RspError  = error_q;
  assign bus.o_Command   = command;
  assign bus.o_BusData   = bus_data;
  assign bus.o_BusValid  = bus_valid;
  assign o_DbgState      = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ArgonALU on the command bus, a
// table of directed requests, and hand-written hold/timeout/reset sequences.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int TRW = COM_WIDTH + WORDSIZE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  seq_state_t dbg_state;
  alu_sequencer_if bus();

  alu_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .i_Clk     (clk),
    .i_Reset   (rst),
    .bus       (bus),
    .o_DbgState(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural ALU: latches on write strobes, answers reads combinationally.
  logic [15:0] m_a = '0, m_b = '0, m_f = '0;
  logic [3:0]  m_op = '0;
  logic [16:0] m_wide;
  logic [15:0] m_y, m_flags;
  logic        m_known;
  logic        alu_stall = 1'b0;

  always @(negedge clk) begin
    if (bus.o_BusValid) begin
      case (bus.o_Command)
        com_latchA:  m_a  = bus.o_BusData;
        com_latchB:  m_b  = bus.o_BusData;
        com_latchF:  m_f  = bus.o_BusData;
        com_latchOp: m_op = bus.o_BusData[3:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    m_wide  = '0;
    m_known = 1'b1;
    case (m_op)
      ALU_ADD: m_wide = {1'b0, m_a} + {1'b0, m_b};
      ALU_ADC: m_wide = {1'b0, m_a} + {1'b0, m_b} + {16'b0, m_f[0]};
      ALU_SUB: m_wide = {1'b0, m_a} - {1'b0, m_b};
      ALU_SBC: m_wide = {1'b0, m_a} - {1'b0, m_b} - {16'b0, m_f[0]};
      ALU_INC: m_wide = {1'b0, m_a} + 17'd1;
      ALU_DEC: m_wide = {1'b0, m_a} - 17'd1;
      ALU_AND: m_wide = {1'b0, m_a & m_b};
      ALU_OR:  m_wide = {1'b0, m_a | m_b};
      ALU_XOR: m_wide = {1'b0, m_a ^ m_b};
      default: m_known = 1'b0;
    endcase
    m_y     = m_wide[15:0];
    m_flags = m_known ? {14'b0, (m_y == 16'h0), m_wide[16]} : 16'h0;
  end

  assign bus.i_BusValid = !alu_stall &&
                          (bus.o_Command == com_outputY || bus.o_Command == com_outputF);
  assign bus.i_BusData  = (bus.o_Command == com_outputY) ? m_y :
                          (bus.o_Command == com_outputF) ? m_flags : 16'h0;

  // Scoreboard of expected bus commands {command, data}.
  logic [TRW-1:0] exp_q[$];
  logic           mon_en = 1'b0;

  always @(negedge clk) begin
    logic [TRW-1:0] e;
    logic           is_wr;
    if (mon_en && bus.o_Command != com_nop) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL cmd_unexpected: got cmd %0d expected none at %0t", bus.o_Command, $time);
      end else begin
        e = exp_q.pop_front();
        is_wr = (e[TRW-1 -: COM_WIDTH] != com_outputY) && (e[TRW-1 -: COM_WIDTH] != com_outputF);
        check("cmd", bus.o_Command, e[TRW-1 -: COM_WIDTH]);
        check("bus_valid", bus.o_BusValid, is_wr);
        if (is_wr) check("bus_data", bus.o_BusData, e[WORDSIZE-1:0]);
      end
    end
  end

  task automatic push_trace(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] fdata);
    exp_q.push_back({com_latchA, a});
    if (!is_unary(op)) exp_q.push_back({com_latchB, b});
    exp_q.push_back({com_latchF, fdata});
    exp_q.push_back({com_latchOp, {12'b0, op}});
    exp_q.push_back({com_outputY, 16'h0});
    exp_q.push_back({com_outputF, 16'h0});
  endtask

  // Called at posedge+1 with the sequencer in IDLE; returns at accept edge+1.
  task automatic send_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic chain);
    bus.i_ReqOp    = op;
    bus.i_ReqA     = a;
    bus.i_ReqB     = b;
    bus.i_ReqChain = chain;
    bus.i_ReqValid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ReqValid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.o_RspValid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.o_RspValid) begin
      n_cmp++;
      n_err++;
      $display("FAIL rsp_timeout: got no o_RspValid expected response within 60 cycles");
    end
  endtask

  task automatic ack_rsp();
    bus.i_RspReady = 1'b1;
    @(posedge clk);
    #1;
    bus.i_RspReady = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        chain;
    logic [15:0] exp_res;
    logic [15:0] exp_flags;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          lat;
    int          ry_cycles;
    logic [15:0] exp_saved;

    vecs[0] = '{ALU_ADD, 16'h1234, 16'h0001, 1'b0, 16'h1235, 16'h0000, 7};
    vecs[1] = '{ALU_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0003, 7};
    vecs[2] = '{ALU_ADC, 16'h0000, 16'h0000, 1'b1, 16'h0001, 16'h0000, 7};
    vecs[3] = '{ALU_INC, 16'h00FF, 16'h5555, 1'b0, 16'h0100, 16'h0000, 6};
    vecs[4] = '{ALU_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 16'h0001, 7};
    vecs[5] = '{ALU_SBC, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0001, 7};
    vecs[6] = '{ALU_DEC, 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h0002, 6};
    vecs[7] = '{ALU_AND, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 16'h0000, 7};
    vecs[8] = '{4'hF,    16'h1234, 16'h0001, 1'b0, 16'h0000, 16'h0000, 7};
    vecs[9] = '{ALU_XOR, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 16'h0002, 7};

    bus.i_ReqValid = 1'b0;
    bus.i_ReqOp    = '0;
    bus.i_ReqA     = '0;
    bus.i_ReqB     = '0;
    bus.i_ReqChain = 1'b0;
    bus.i_RspReady = 1'b0;
    exp_saved      = 16'h0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_state", dbg_state, IDLE);
    check("rst_command", bus.o_Command, com_nop);
    check("rst_bus_valid", bus.o_BusValid, 1'b0);
    check("rst_bus_data", bus.o_BusData, 16'h0);
    check("rst_rsp_valid", bus.o_RspValid, 1'b0);
    check("rst_rsp_result", bus.o_RspResult, 16'h0);
    check("rst_rsp_flags", bus.o_RspFlags, 16'h0);
    check("rst_rsp_error", bus.o_RspError, 1'b0);
    check("rst_req_ready", bus.o_ReqReady, 1'b1);

    // Table-driven requests
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_trace(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain ? exp_saved : 16'h0);
      send_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain);
      wait_rsp(lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_result", i), bus.o_RspResult, vecs[i].exp_res);
      check($sformatf("v%0d_flags", i), bus.o_RspFlags, vecs[i].exp_flags);
      check($sformatf("v%0d_error", i), bus.o_RspError, 1'b0);
      check($sformatf("v%0d_req_ready_busy", i), bus.o_ReqReady, 1'b0);
      check($sformatf("v%0d_trace_done", i), exp_q.size(), 0);
      ack_rsp();
      check($sformatf("v%0d_back_idle", i), bus.o_ReqReady, 1'b1);
      exp_saved = vecs[i].exp_flags;
    end

    // Response back-pressure: outputs hold, no new request taken, no bus traffic
    push_trace(ALU_ADD, 16'h0003, 16'h0004, 16'h0000);
    send_req(ALU_ADD, 16'h0003, 16'h0004, 1'b0);
    wait_rsp(lat);
    exp_saved = 16'h0000;
    push_trace(ALU_INC, 16'h0010, 16'h0000, 16'h0000);
    bus.i_ReqOp    = ALU_INC;
    bus.i_ReqA     = 16'h0010;
    bus.i_ReqB     = 16'h0000;
    bus.i_ReqChain = 1'b0;
    bus.i_ReqValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", bus.o_RspValid, 1'b1);
      check("hold_result", bus.o_RspResult, 16'h0007);
      check("hold_req_ready", bus.o_ReqReady, 1'b0);
      check("hold_command", bus.o_Command, com_nop);
    end
    bus.i_RspReady = 1'b1;
    @(posedge clk);
    #1;
    bus.i_RspReady = 1'b0;
    check("release_state", dbg_state, IDLE);
    check("release_req_ready", bus.o_ReqReady, 1'b1);
    @(posedge clk);
    #1;
    bus.i_ReqValid = 1'b0;
    check("b2b_accept_state", dbg_state, WR_A);
    wait_rsp(lat);
    check("b2b_result", bus.o_RspResult, 16'h0011);
    check("b2b_trace_done", exp_q.size(), 0);
    ack_rsp();

    // Leave a nonzero saved flags word, then time out in RD_Y
    push_trace(ALU_ADD, 16'hFFFF, 16'h0002, 16'h0000);
    send_req(ALU_ADD, 16'hFFFF, 16'h0002, 1'b0);
    wait_rsp(lat);
    check("pre_to_flags", bus.o_RspFlags, 16'h0001);
    ack_rsp();
    exp_saved = 16'h0001;

    mon_en    = 1'b0;
    alu_stall = 1'b1;
    send_req(ALU_ADD, 16'h0001, 16'h0001, 1'b0);
    ry_cycles = 0;
    lat = 1;
    while (!bus.o_RspValid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (dbg_state == RD_Y) ry_cycles++;
    end
    check("to_rsp_valid", bus.o_RspValid, 1'b1);
    check("to_rd_y_cycles", ry_cycles, 15);
    check("to_error", bus.o_RspError, 1'b1);
    check("to_result", bus.o_RspResult, 16'h0);
    check("to_flags", bus.o_RspFlags, 16'h0);
    ack_rsp();
    alu_stall = 1'b0;

    // Saved flags survive the aborted op
    mon_en = 1'b1;
    push_trace(ALU_ADC, 16'h0000, 16'h0000, exp_saved);
    send_req(ALU_ADC, 16'h0000, 16'h0000, 1'b1);
    wait_rsp(lat);
    check("post_to_result", bus.o_RspResult, 16'h0001);
    check("post_to_error", bus.o_RspError, 1'b0);
    check("post_to_trace_done", exp_q.size(), 0);
    ack_rsp();

    // Reset in WR_OP aborts and clears the saved flags
    mon_en = 1'b0;
    send_req(ALU_ADD, 16'hFFFF, 16'h0001, 1'b0);
    wait_rsp(lat);
    ack_rsp();
    send_req(ALU_ADD, 16'h0001, 16'h0002, 1'b0);
    lat = 0;
    while (dbg_state != WR_OP && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rst_mid_reached_wr_op", dbg_state, WR_OP);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_state", dbg_state, IDLE);
    check("rst_mid_command", bus.o_Command, com_nop);
    check("rst_mid_rsp_valid", bus.o_RspValid, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    push_trace(ALU_ADC, 16'h0000, 16'h0000, 16'h0000);
    send_req(ALU_ADC, 16'h0000, 16'h0000, 1'b1);
    wait_rsp(lat);
    check("rst_mid_chain_result", bus.o_RspResult, 16'h0000);
    check("rst_mid_chain_flags", bus.o_RspFlags, 16'h0002);
    check("rst_mid_trace_done", exp_q.size(), 0);
    ack_rsp();
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-bus master for ArgonALU; turns one operation request {op, A, B, chain} into the ALU command sequence: latch A/B/flags/op, read Y, read F.
- Returns a {result, flags} response on a valid/ready handshake.
- Keeps the last flags word, so multi-word ADC/SBC chains need no software flag shuffling.
- Sits between the CPU control unit and the ALU's bus interface; it is the only driver of the ALU command bus.

Parameters:
- WORDSIZE, 16, data/flags word width (from constants_pkg).
- TIMEOUT_CYCLES, 15, maximum cycles to wait for i_BusValid in a read state before aborting.

Ports:
- i_Clk  in  1  clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_ReqValid  in  1  request valid.
- o_ReqReady  out  1  high only in IDLE.
- i_ReqOp  in  4  ALU opcode (alu_pkg ALU_* values).
- i_ReqA  in  WORDSIZE  operand A.
- i_ReqB  in  WORDSIZE  operand B.
- i_ReqChain  in  1  1 = write the saved flags word before the op; 0 = write 0x0000.
- o_RspValid  out  1  response valid.
- i_RspReady  in  1  response accept.
- o_RspResult  out  WORDSIZE  ALU Y.
- o_RspFlags  out  WORDSIZE  ALU F word (opaque, zero-extended).
- o_RspError  out  1  response aborted by timeout; result/flags are 0.
- o_Command  out  COM_WIDTH  ALU bus command.
- o_BusData  out  WORDSIZE  data to ALU.
- o_BusValid  out  1  write strobe to ALU.
- i_BusData  in  WORDSIZE  ALU o_data.
- i_BusValid  in  1  ALU o_valid.

Behaviour:
- Reset (synchronous, i_Clk edge with i_Reset=1):
  - state=IDLE, all response outputs 0, o_Command=com_nop, o_BusValid=0, o_BusData=0.
  - Saved flags=0, timeout counter=0.
  - Reset mid-sequence aborts immediately; no response is produced.
- All bus outputs are registered-state decodes (Moore); o_BusValid=1 only in WR_* states.
- States and per-state actions:
  - IDLE: o_ReqReady=1. On i_ReqValid, capture op/A/B/chain → WR_A.
  - WR_A: command com_latchA, data=A → WR_F if op is ALU_INC or ALU_DEC, else WR_B.
  - WR_B: command com_latchB, data=B → WR_F.
  - WR_F: command com_latchF, data = chain ? saved flags : 0x0000 → WR_OP.
  - WR_OP: command com_latchOp, data={12'b0,op} → RD_Y.
  - RD_Y: command com_outputY. If i_BusValid: capture i_BusData as result → RD_F.
  - RD_F: command com_outputF. If i_BusValid: capture flags and update saved flags → RESP.
  - RESP: o_RspValid=1, outputs held stable. On i_RspReady → IDLE. No new request is accepted until the handshake completes.
- Read states sample i_BusData at the clock edge while the command is presented; the ALU responds combinationally in the same cycle.
- Timeout counter:
  - Clears on entry to RD_Y and RD_F; increments each cycle with i_BusValid=0.
  - At TIMEOUT_CYCLES → RESP with o_RspError=1, result=0, flags=0, saved flags unchanged.
- Latency, request accept edge to o_RspValid high, with no stalls: 7 cycles for binary ops, 6 for INC/DEC.
- Back-to-back: a new request is accepted on the cycle after the response handshake, since IDLE is re-entered.
- Saved flags persist across requests. They are not cleared by non-chained ops; every completed op overwrites them.
- Unknown opcodes are passed through unchanged; the ALU returns 0.

Decomposition:
- constants_pkg: add com_nop and COM_WIDTH; reuse the existing com_latchA/B/F/Op and com_outputY/F encodings.
- alu_pkg: add seq_state_t enum {IDLE, WR_A, WR_B, WR_F, WR_OP, RD_Y, RD_F, RESP} and an is_unary(op) function.
- Single module, no sub-module. The timeout counter is inline, under 20 lines.

Test Plan:
- ADD A=0x1234 B=0x0001 chain=0 → result 0x1235, carry=0, zero=0, o_RspValid 7 cycles after accept. Command trace: A, B, F(0x0000), Op, Y, F.
- ADD 0xFFFF+0x0001, then ADC 0x0000+0x0000 chain=1 → first result 0x0000 with carry=1, zero=1. Second WR_F drives the saved flags, second result 0x0001.
- INC A=0x00FF → no com_latchB issued, result 0x0100, latency 6 cycles.
- Hold i_RspReady=0 for 5 cycles → o_RspValid and outputs stable, o_ReqReady=0, no bus commands. Release → IDLE next cycle; new request accepted.
- Force i_BusValid=0 in RD_Y → o_RspError=1 after 15 cycles, result=0, saved flags unchanged.
- Assert i_Reset in WR_OP → next cycle IDLE, o_Command=com_nop, o_RspValid=0, saved flags=0.
